// File: rtl/ws2811_tx_pkg.sv
// ----------------------------------------------------------------------------
// ws2811_tx_pkg
// Shared definitions for the WS2811/WS2812 serializer:
//   - state_t        : serializer FSM state encoding
//   - *_DEF          : default timing constants for a 50 MHz clock
//   - R/G/B_MSB/LSB  : bit positions of the colour fields in a 24-bit pixel
//   - grb_word()     : packs three channels into the on-wire GRB order
// ----------------------------------------------------------------------------
package ws2811_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BITS  = 2'd2,
        ST_LATCH = 2'd3
    } state_t;

    // Timing defaults at 50 MHz (20 ns per clock).
    localparam int T0H_CYC_DEF   = 20;    // 0.40 us
    localparam int T1H_CYC_DEF   = 40;    // 0.80 us
    localparam int BIT_CYC_DEF   = 63;    // ~1.25 us
    localparam int RESET_CYC_DEF = 2600;  // 52 us latch
    localparam int NPIX_W_DEF    = 10;

    // Pixel field positions: R[23:16], G[15:8], B[7:0].
    localparam int PIX_W = 24;
    localparam int R_MSB = 23;
    localparam int R_LSB = 16;
    localparam int G_MSB = 15;
    localparam int G_LSB = 8;
    localparam int B_MSB = 7;
    localparam int B_LSB = 0;

    // The LED string expects green first, then red, then blue.
    function automatic logic [PIX_W-1:0] grb_word(input logic [7:0] r,
                                                  input logic [7:0] g,
                                                  input logic [7:0] b);
        return {g, r, b};
    endfunction

endpackage

// File: rtl/ws2811_tx_gamma.sv
// ----------------------------------------------------------------------------
// ws2811_tx_gamma
// Combinational 8-bit gamma lookup (gamma ~2.8), one instance per channel.
// Ports:
//   value     in  8  linear channel intensity
//   corrected out 8  perceptually corrected intensity
// ----------------------------------------------------------------------------
module ws2811_tx_gamma (
    input  logic [7:0] value,
    output logic [7:0] corrected
);

    localparam logic [7:0] LUT [256] = '{
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
        8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1,   8'd1,
        8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,
        8'd2,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   8'd5,   8'd5,   8'd5,
        8'd5,   8'd6,   8'd6,   8'd6,   8'd6,   8'd7,   8'd7,   8'd7,   8'd7,   8'd8,   8'd8,   8'd8,   8'd9,   8'd9,   8'd9,   8'd10,
        8'd10,  8'd10,  8'd11,  8'd11,  8'd11,  8'd12,  8'd12,  8'd13,  8'd13,  8'd13,  8'd14,  8'd14,  8'd15,  8'd15,  8'd16,  8'd16,
        8'd17,  8'd17,  8'd18,  8'd18,  8'd19,  8'd19,  8'd20,  8'd20,  8'd21,  8'd21,  8'd22,  8'd22,  8'd23,  8'd24,  8'd24,  8'd25,
        8'd25,  8'd26,  8'd27,  8'd27,  8'd28,  8'd29,  8'd29,  8'd30,  8'd31,  8'd32,  8'd32,  8'd33,  8'd34,  8'd35,  8'd35,  8'd36,
        8'd37,  8'd38,  8'd39,  8'd39,  8'd40,  8'd41,  8'd42,  8'd43,  8'd44,  8'd45,  8'd46,  8'd47,  8'd48,  8'd49,  8'd50,  8'd50,
        8'd51,  8'd52,  8'd54,  8'd55,  8'd56,  8'd57,  8'd58,  8'd59,  8'd60,  8'd61,  8'd62,  8'd63,  8'd64,  8'd66,  8'd67,  8'd68,
        8'd69,  8'd70,  8'd72,  8'd73,  8'd74,  8'd75,  8'd77,  8'd78,  8'd79,  8'd81,  8'd82,  8'd83,  8'd85,  8'd86,  8'd87,  8'd89,
        8'd90,  8'd92,  8'd93,  8'd95,  8'd96,  8'd98,  8'd99,  8'd101, 8'd102, 8'd104, 8'd105, 8'd107, 8'd109, 8'd110, 8'd112, 8'd114,
        8'd115, 8'd117, 8'd119, 8'd120, 8'd122, 8'd124, 8'd126, 8'd127, 8'd129, 8'd131, 8'd133, 8'd135, 8'd137, 8'd138, 8'd140, 8'd142,
        8'd144, 8'd146, 8'd148, 8'd150, 8'd152, 8'd154, 8'd156, 8'd158, 8'd160, 8'd162, 8'd164, 8'd167, 8'd169, 8'd171, 8'd173, 8'd175,
        8'd177, 8'd180, 8'd182, 8'd184, 8'd186, 8'd189, 8'd191, 8'd193, 8'd196, 8'd198, 8'd200, 8'd203, 8'd205, 8'd208, 8'd210, 8'd213,
        8'd215, 8'd218, 8'd220, 8'd223, 8'd225, 8'd228, 8'd231, 8'd233, 8'd236, 8'd239, 8'd241, 8'd244, 8'd247, 8'd249, 8'd252, 8'd255
    };

    assign corrected = LUT[value];

endmodule

// File: rtl/ws2811_tx.sv
// ----------------------------------------------------------------------------
// ws2811_tx
// Serializes a frame of 24-bit RGB pixels into the WS2811/WS2812 NRZ
// waveform: GRB order, MSB first, followed by a low latch interval.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle frame start (ignored while busy or on done)
//   num_pixels   pixels in the frame, sampled on an accepted start
//   gamma_en     apply gamma to every channel, sampled on each pixel load
//   pix_data     R[23:16] G[15:8] B[7:0]
//   pix_valid    pix_data is valid
//   pix_ready    pixel accepted on pix_valid && pix_ready
//   dout         registered serial line to the LED string
//   busy         high from accepted start until done
//   done         one-cycle pulse when the latch interval ends
//   underrun     one-cycle pulse when the next pixel was not available
// ----------------------------------------------------------------------------
module ws2811_tx
    import ws2811_tx_pkg::*;
#(
    parameter int T0H_CYC   = T0H_CYC_DEF,
    parameter int T1H_CYC   = T1H_CYC_DEF,
    parameter int BIT_CYC   = BIT_CYC_DEF,
    parameter int RESET_CYC = RESET_CYC_DEF,
    parameter int NPIX_W    = NPIX_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [NPIX_W-1:0] num_pixels,
    input  logic              gamma_en,
    input  logic [PIX_W-1:0]  pix_data,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              dout,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int CYC_MAX = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
    localparam int CYC_W   = $clog2(CYC_MAX + 1);

    localparam logic [CYC_W-1:0]  BIT_LAST    = CYC_W'(BIT_CYC - 1);
    localparam logic [CYC_W-1:0]  BIT_PRELAST = CYC_W'(BIT_CYC - 2);
    localparam logic [CYC_W-1:0]  LATCH_LAST  = CYC_W'(RESET_CYC - 1);
    localparam logic [CYC_W-1:0]  T0H         = CYC_W'(T0H_CYC);
    localparam logic [CYC_W-1:0]  T1H         = CYC_W'(T1H_CYC);
    localparam logic [4:0]        LAST_BIT    = 5'd23;
    localparam logic [NPIX_W-1:0] ONE_PIX     = NPIX_W'(1);

    state_t            state;
    logic [CYC_W-1:0]  cyc;
    logic [4:0]        bit_idx;
    logic [NPIX_W-1:0] remaining;
    logic [PIX_W-1:0]  sr;

    logic [7:0]        r_gam, g_gam, b_gam;
    logic [PIX_W-1:0]  load_word;
    logic [CYC_W-1:0]  cyc_inc;
    logic [CYC_W-1:0]  hi_len;
    logic              take;

    ws2811_tx_gamma u_gamma_r (.value(pix_data[R_MSB:R_LSB]), .corrected(r_gam));
    ws2811_tx_gamma u_gamma_g (.value(pix_data[G_MSB:G_LSB]), .corrected(g_gam));
    ws2811_tx_gamma u_gamma_b (.value(pix_data[B_MSB:B_LSB]), .corrected(b_gam));

    always_comb begin
        // NOTE: assign a default before any condition so no path leaves the
        // signal unassigned, which would infer a latch.
        load_word = grb_word(pix_data[R_MSB:R_LSB], pix_data[G_MSB:G_LSB],
                             pix_data[B_MSB:B_LSB]);
        if (gamma_en) begin
            load_word = grb_word(r_gam, g_gam, b_gam);
        end
    end

    assign take    = pix_valid && pix_ready;
    assign cyc_inc = cyc + 1'b1;
    assign hi_len  = sr[PIX_W-1] ? T1H : T0H;

    // dout is registered, so every transition computes the level the line
    // must carry in the *next* cycle. A fresh bit always starts high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cyc       <= '0;
            bit_idx   <= '0;
            remaining <= '0;
            sr        <= '0;
            dout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            pix_ready <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            done      <= 1'b0;
            underrun  <= 1'b0;
            pix_ready <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    dout <= 1'b0;
                    // A start landing on the done cycle is deliberately dropped.
                    if (start && !done) begin
                        busy      <= 1'b1;
                        remaining <= num_pixels;
                        cyc       <= '0;
                        if (num_pixels == '0) begin
                            state <= ST_LATCH;
                        end else begin
                            state     <= ST_LOAD;
                            pix_ready <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    dout <= 1'b0;
                    if (take) begin
                        sr      <= load_word;
                        cyc     <= '0;
                        bit_idx <= '0;
                        dout    <= 1'b1;
                        state   <= ST_BITS;
                    end else begin
                        pix_ready <= 1'b1;
                    end
                end

                ST_BITS: begin
                    if (cyc != BIT_LAST) begin
                        cyc  <= cyc_inc;
                        dout <= (cyc_inc < hi_len);
                        // Open the handover window for the final cycle of bit 23.
                        pix_ready <= (bit_idx == LAST_BIT) && (cyc == BIT_PRELAST) &&
                                     (remaining > ONE_PIX);
                    end else if (bit_idx != LAST_BIT) begin
                        cyc     <= '0;
                        bit_idx <= bit_idx + 5'd1;
                        sr      <= {sr[PIX_W-2:0], 1'b0};
                        dout    <= 1'b1;
                    end else begin
                        remaining <= remaining - ONE_PIX;
                        cyc       <= '0;
                        bit_idx   <= '0;
                        if (remaining > ONE_PIX) begin
                            if (take) begin
                                sr   <= load_word;
                                dout <= 1'b1;
                            end else begin
                                // Source missed the handover: wait in LOAD with the line low.
                                underrun  <= 1'b1;
                                dout      <= 1'b0;
                                pix_ready <= 1'b1;
                                state     <= ST_LOAD;
                            end
                        end else begin
                            dout  <= 1'b0;
                            state <= ST_LATCH;
                        end
                    end
                end

                ST_LATCH: begin
                    dout <= 1'b0;
                    if (cyc == LATCH_LAST) begin
                        cyc   <= '0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cyc <= cyc_inc;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2811_tx.sv
// ----------------------------------------------------------------------------
// tb_ws2811_tx
// Self-checking bench for ws2811_tx. Accepted pixels push their expected
// 24-bit GRB sequence into a scoreboard queue; a line monitor decodes dout
// into bits by high time and pops/compares them.
// ----------------------------------------------------------------------------
module tb_ws2811_tx;

    localparam int T0H  = 20;
    localparam int T1H  = 40;
    localparam int BITC = 63;
    localparam int RSTC = 2600;
    localparam int NW   = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [NW-1:0] num_pixels;
    logic          gamma_en  = 1'b0;
    logic [23:0]   pix_data  = '0;
    logic          pix_valid = 1'b0;
    logic          pix_ready, dout, busy, done, underrun;

    always #5 clk = ~clk;

    ws2811_tx #(
        .T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RESET_CYC(RSTC), .NPIX_W(NW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pixels(num_pixels),
        .gamma_en(gamma_en), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_ready(pix_ready), .dout(dout), .busy(busy), .done(done),
        .underrun(underrun)
    );

    typedef struct {
        logic [23:0] data;
        logic        gam;
    } pix_t;

    pix_t pix_q[$];   // pixels waiting to be offered
    logic exp_q[$];   // scoreboard: expected bits in wire order

    int n_checks = 0;
    int n_fail   = 0;

    int cyc_cnt = 0, busy_cnt = 0, rdy_cnt = 0, unr_cnt = 0, done_cnt = 0;
    int period_cnt = 0, hi_cnt = 0, last_rise = 0, hs_cyc = 0;
    bit prev_dout = 1'b0, have_rise = 1'b0, contig_en = 1'b0, hs_pending = 1'b0;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Reference gamma points only for the intensities this bench uses.
    function automatic logic [7:0] gamma_ref(input logic [7:0] v);
        case (v)
            8'h00:   return 8'h00;
            8'h80:   return 8'h25;
            8'hFF:   return 8'hFF;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push_expected(input logic [23:0] d, input logic gam);
        logic [7:0]  r, g, b;
        logic [23:0] w;
        r = d[23:16];
        g = d[15:8];
        b = d[7:0];
        if (gam) begin
            r = gamma_ref(r);
            g = gamma_ref(g);
            b = gamma_ref(b);
        end
        w = {g, r, b};
        for (int i = 23; i >= 0; i--) exp_q.push_back(w[i]);
    endtask

    // Pixel source: offers the head of pix_q.
    always @(negedge clk) begin
        if (pix_q.size() != 0) begin
            pix_valid = 1'b1;
            pix_data  = pix_q[0].data;
            gamma_en  = pix_q[0].gam;
        end else begin
            pix_valid = 1'b0;
        end
    end

    // Scoreboard producer: on each accepted pixel, queue its expected bits.
    always @(posedge clk) begin
        if (rst_n && pix_valid && pix_ready) begin
            push_expected(pix_data, gamma_en);
            if (pix_q.size() != 0) pix_q.delete(0);
            hs_cyc     = cyc_cnt;
            hs_pending = 1'b1;
        end
    end

    // Line monitor: decodes bits by high time and checks bit periods.
    always @(negedge clk) begin
        logic exp_bit;
        cyc_cnt++;
        if (!rst_n) begin
            prev_dout  = 1'b0;
            hi_cnt     = 0;
            hs_pending = 1'b0;
            have_rise  = 1'b0;
        end else begin
            if (busy)      busy_cnt++;
            if (pix_ready) rdy_cnt++;
            if (underrun)  unr_cnt++;
            if (done)      done_cnt++;
            if (dout && !prev_dout) begin
                if (hs_pending) begin
                    check("first_rise_latency", cyc_cnt - hs_cyc, 1);
                    hs_pending = 1'b0;
                end
                if (contig_en && have_rise) begin
                    check("bit_period", cyc_cnt - last_rise, BITC);
                    period_cnt++;
                end
                last_rise = cyc_cnt;
                have_rise = 1'b1;
                hi_cnt    = 1;
            end else if (dout) begin
                hi_cnt++;
            end else if (prev_dout) begin
                check("bit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_bit = exp_q.pop_front();
                    check("hi_width", hi_cnt, exp_bit ? T1H : T0H);
                end
            end
            prev_dout = dout;
        end
    end

    task automatic clear_counters();
        busy_cnt   = 0;
        rdy_cnt    = 0;
        unr_cnt    = 0;
        done_cnt   = 0;
        period_cnt = 0;
        have_rise  = 1'b0;
    endtask

    task automatic start_frame(input int n);
        @(negedge clk);
        start      = 1'b1;
        num_pixels = NW'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int i;
        i = 0;
        while (!done && i < limit) begin
            @(negedge clk);
            i++;
        end
        check("done_seen", done, 1);
        check("busy_low_at_done", busy, 0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_pixels = '0;
        #1;
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_underrun", underrun, 0);
        check("rst_pix_ready", pix_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Single pixel 0xFF0000 with gamma: G=00, R=FF, B=00 on the wire.
        clear_counters();
        pix_q.push_back('{data: 24'hFF0000, gam: 1'b1});
        start_frame(1);
        wait_done(6000);
        check("single_busy_len", busy_cnt, 1 + 24 * BITC + RSTC);
        check("single_bits_left", exp_q.size(), 0);
        check("single_ready_cycles", rdy_cnt, 1);
        @(negedge clk);
        check("done_one_cycle", done, 0);

        // 0x808080 with gamma on, then off; gamma_en sampled per pixel.
        clear_counters();
        pix_q.push_back('{data: 24'h808080, gam: 1'b1});
        pix_q.push_back('{data: 24'h808080, gam: 1'b0});
        start_frame(2);
        wait_done(10000);
        check("gamma_bits_left", exp_q.size(), 0);
        check("gamma_ready_cycles", rdy_cnt, 2);

        // Three pixels, valid held high: contiguous 63-cycle bits.
        clear_counters();
        contig_en = 1'b1;
        pix_q.push_back('{data: 24'hA5C30F, gam: 1'b0});
        pix_q.push_back('{data: 24'h00FF00, gam: 1'b0});
        pix_q.push_back('{data: 24'h5A3CF0, gam: 1'b0});
        start_frame(3);
        wait_done(12000);
        contig_en = 1'b0;
        check("contig_ready_cycles", rdy_cnt, 3);
        check("contig_periods", period_cnt, 71);
        check("contig_busy_len", busy_cnt, 1 + 72 * BITC + RSTC);
        check("contig_bits_left", exp_q.size(), 0);
        check("contig_no_underrun", unr_cnt, 0);

        // Underrun: second pixel arrives late.
        clear_counters();
        pix_q.push_back('{data: 24'h123456, gam: 1'b0});
        start_frame(2);
        i = 0;
        while (unr_cnt == 0 && i < 2000) begin
            @(negedge clk);
            i++;
        end
        check("underrun_seen", unr_cnt, 1);
        repeat (100) @(negedge clk);
        check("underrun_dout_low", dout, 0);
        check("underrun_ready_waiting", pix_ready, 1);
        check("underrun_busy", busy, 1);
        pix_q.push_back('{data: 24'hFEDCBA, gam: 1'b0});
        wait_done(6000);
        check("underrun_single_pulse", unr_cnt, 1);
        check("underrun_bits_left", exp_q.size(), 0);

        // Zero-pixel frame; a start while busy and a start on done are ignored.
        clear_counters();
        start_frame(0);
        repeat (100) @(negedge clk);
        start      = 1'b1;
        num_pixels = NW'(1);
        @(negedge clk);
        start = 1'b0;
        wait_done(4000);
        start      = 1'b1;
        num_pixels = '0;
        @(negedge clk);
        start = 1'b0;
        check("start_on_done_ignored", busy, 0);
        check("zero_busy_len", busy_cnt, RSTC);
        check("zero_no_ready", rdy_cnt, 0);
        check("zero_bits_left", exp_q.size(), 0);

        // Reset while waiting in LOAD: pix_ready drops asynchronously.
        start_frame(1);
        @(negedge clk);
        check("load_ready_before_rst", pix_ready, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_pix_ready", pix_ready, 0);
        check("async_rst_busy_load", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-bit while dout is high.
        clear_counters();
        pix_q.push_back('{data: 24'hFFFFFF, gam: 1'b0});
        start_frame(1);
        i = 0;
        while (!dout && i < 50) begin
            @(negedge clk);
            i++;
        end
        check("dout_rose", dout, 1);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_dout", dout, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", pix_ready, 0);
        exp_q.delete();
        pix_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("no_done_after_abort", done_cnt, 0);

        // Normal frame after reset.
        clear_counters();
        pix_q.push_back('{data: 24'h00FF80, gam: 1'b0});
        start_frame(1);
        wait_done(6000);
        check("post_rst_busy_len", busy_cnt, 1 + 24 * BITC + RSTC);
        check("post_rst_bits_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
